// File: rtl/led_pwm_if.sv
// rtl/led_pwm_if.sv - io_port input and PWM output bundle of led_pwm
//
// Signals:
//   io_port[7:0]  colour enables [2:0] (b2 blue, b1 green, b0 red), [3] instant mode, [7:4] ignored
//   r, g, b       active-high PWM drives to the led
//   period_start  one-clock pulse on each PWM period boundary
// Modports:
//   master  computer side: drives io_port, observes the outputs
//   slave   led_pwm side: reads io_port, drives the outputs
interface led_pwm_if;
  logic [7:0] io_port;
  logic       r;
  logic       g;
  logic       b;
  logic       period_start;

  modport master (output io_port, input r, g, b, period_start);
  modport slave  (input io_port, output r, g, b, period_start);
endinterface

// File: rtl/led_pwm.sv
// rtl/led_pwm.sv - three-channel fading LED PWM driven by io_port colour bits
//
// Ports:
//   clk      dot clock from the pll
//   reset_n  synchronous active-low reset
//   bus      led_pwm_if.slave: io_port in; r, g, b, period_start out
// Parameters:
//   CLK_DIV    clocks per PWM count (1..65535)
//   FADE_STEP  level change per PWM period while fading (1..255)
//   MAX_LEVEL  full-on level cap (1..255)
// Optional feature macro LED_PWM_GAMMA_EN:
//   defined   duty = (level*(level+1))>>8, computed combinationally (no added latency)
//   undefined duty = level
module led_pwm #(
  parameter int CLK_DIV   = 10,
  parameter int FADE_STEP = 8,
  parameter int MAX_LEVEL = 255
) (
  input  logic     clk,
  input  logic     reset_n,
  led_pwm_if.slave bus
);

  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
  localparam logic [8:0]  STEP9    = 9'(FADE_STEP);
  localparam logic [7:0]  STEP8    = 8'(FADE_STEP);
  localparam logic [8:0]  MAX9     = 9'(MAX_LEVEL);
  localparam logic [7:0]  MAX8     = 8'(MAX_LEVEL);

  logic [15:0]      presc_q, presc_d;
  logic [7:0]       pwm_cnt_q, pwm_cnt_d;
  logic [2:0][7:0]  level_q, level_d;
  logic [2:0]       target_q, target_d;
  logic [2:0]       rgb_q, rgb_d;
  logic             period_start_q, period_start_d;

  logic             tick;
  logic             boundary;
  logic [8:0]       up_sum;
  logic [2:0][7:0]  duty;

`ifdef LED_PWM_GAMMA_EN
  // level*(level+1) peaks at 255*256 = 65280, so 16 bits never overflow
  // and the top byte maps 255 back to 255 for a constant-high channel.
  logic [2:0][15:0] gamma_prod;

  always_comb begin
    gamma_prod = '0;
    duty       = '0;
    for (int i = 0; i < 3; i++) begin
      gamma_prod[i] = {8'd0, level_q[i]} * ({8'd0, level_q[i]} + 16'd1);
      duty[i]       = gamma_prod[i][15:8];
    end
  end
`else
  assign duty = level_q;
`endif

  always_comb begin
    tick           = (presc_q == DIV_LAST);
    boundary       = tick && (pwm_cnt_q == 8'd254);
    presc_d        = tick ? 16'd0 : presc_q + 16'd1;
    pwm_cnt_d      = pwm_cnt_q;
    period_start_d = boundary;
    target_d       = target_q;
    level_d        = level_q;
    rgb_d          = '0;
    up_sum         = '0;

    if (boundary) begin
      pwm_cnt_d = 8'd0;
      target_d  = bus.io_port[2:0];
    end else if (tick) begin
      pwm_cnt_d = pwm_cnt_q + 8'd1;
    end

    for (int i = 0; i < 3; i++) begin
      // 9-bit sum so a fade-up near the top saturates instead of wrapping.
      up_sum = {1'b0, level_q[i]} + STEP9;
      if (boundary) begin
        if (bus.io_port[3]) begin
          level_d[i] = bus.io_port[i] ? MAX8 : 8'd0;
        end else if (bus.io_port[i]) begin
          level_d[i] = (up_sum > MAX9) ? MAX8 : up_sum[7:0];
        end else begin
          level_d[i] = (level_q[i] < STEP8) ? 8'd0 : level_q[i] - STEP8;
        end
      end
      // pwm_cnt never reaches 255, so duty 255 holds the output high.
      rgb_d[i] = (pwm_cnt_q < duty[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      presc_q        <= '0;
      pwm_cnt_q      <= '0;
      level_q        <= '0;
      target_q       <= '0;
      rgb_q          <= '0;
      period_start_q <= 1'b0;
    end else begin
      presc_q        <= presc_d;
      pwm_cnt_q      <= pwm_cnt_d;
      level_q        <= level_d;
      target_q       <= target_d;
      rgb_q          <= rgb_d;
      period_start_q <= period_start_d;
    end
  end

  // The latched targets and the upper io_port nibble have no consumer.
  logic unused_bits;
  assign unused_bits = ^{bus.io_port[7:4], target_q};

  assign bus.r            = rgb_q[0];
  assign bus.g            = rgb_q[1];
  assign bus.b            = rgb_q[2];
  assign bus.period_start = period_start_q;

endmodule

// File: tb/tb_led_pwm.sv
// tb/tb_led_pwm.sv - scoreboard bench for led_pwm across several parameter sets
module tb_led_pwm;

  localparam int NI = 5;
  // Instance 0: defaults; 1: CLK_DIV=2; 2: CLK_DIV=1; 3: FADE_STEP=100; 4: MAX_LEVEL=128
  localparam logic [NI-1:0][15:0] DIV_P  = {16'd1, 16'd1, 16'd1, 16'd2, 16'd10};
  localparam logic [NI-1:0][7:0]  FADE_P = {8'd8, 8'd100, 8'd8, 8'd8, 8'd8};
  localparam logic [NI-1:0][7:0]  MAX_P  = {8'd128, 8'd255, 8'd255, 8'd255, 8'd255};

  typedef struct packed {
    int r;
    int g;
    int b;
    int len;
  } exp_t;

  logic          clk = 1'b0;
  logic [NI-1:0] rstn = '0;
  logic [NI-1:0] rst_at_edge = '0;
  logic [7:0]    io_v [NI];
  logic [NI-1:0] r_v, g_v, b_v, ps_v;

  exp_t exp_q [NI][$];
  exp_t mon_e;

  int checks = 0;
  int errors = 0;
  int e = 0;

  int  since_rel [NI];
  int  pre_hi [NI];
  int  len_c [NI];
  int  hr [NI];
  int  hg [NI];
  int  hb [NI];
  bit  active [NI];
  bit  prev_ps [NI];
  bit  was_rst [NI];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    led_pwm_if u_if ();
    assign u_if.io_port = io_v[gi];
    assign r_v[gi]  = u_if.r;
    assign g_v[gi]  = u_if.g;
    assign b_v[gi]  = u_if.b;
    assign ps_v[gi] = u_if.period_start;
    led_pwm #(
      .CLK_DIV  (int'(DIV_P[gi])),
      .FADE_STEP(int'(FADE_P[gi])),
      .MAX_LEVEL(int'(MAX_P[gi]))
    ) u_dut (
      .clk    (clk),
      .reset_n(rstn[gi]),
      .bus    (u_if.slave)
    );
  end

  always @(posedge clk) rst_at_edge <= rstn;

  task automatic chk(input string name, input int inst, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s inst%0d: got %0d, expected %0d", name, inst, act, expv);
    end
  endtask

  function automatic int duty_of(input int lvl);
`ifdef LED_PWM_GAMMA_EN
    return (lvl * (lvl + 1)) >> 8;
`else
    return lvl;
`endif
  endfunction

  // Expected high-clock counts for the period that follows one boundary.
  task automatic push_exp(input int i, input int lr, input int lg, input int lb);
    exp_t x;
    x.r   = duty_of(lr) * int'(DIV_P[i]);
    x.g   = duty_of(lg) * int'(DIV_P[i]);
    x.b   = duty_of(lb) * int'(DIV_P[i]);
    x.len = 255 * int'(DIV_P[i]);
    exp_q[i].push_back(x);
  endtask

  task automatic run_to(input int t);
    repeat (t - e) @(posedge clk);
    e = t;
    #1;
  endtask

  task automatic release_inst(input int i);
    @(posedge clk);
    #1;
    rstn[i] = 1'b1;
    e = 0;
  endtask

  // Monitor: a window runs from the clock after one period_start through the
  // next period_start inclusive; within it each pwm_cnt value is seen CLK_DIV
  // times with the level latched at the opening boundary.
  initial begin
    for (int i = 0; i < NI; i++) begin
      was_rst[i] = 1'b0;
      active[i]  = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        if (!rst_at_edge[i]) begin
          if (!was_rst[i])
            chk("reset_outputs", i, int'({r_v[i], g_v[i], b_v[i], ps_v[i]}), 0);
          was_rst[i]   = 1'b1;
          active[i]    = 1'b0;
          since_rel[i] = 0;
          pre_hi[i]    = 0;
          prev_ps[i]   = 1'b0;
        end else begin
          was_rst[i] = 1'b0;
          since_rel[i]++;
          if (active[i]) begin
            len_c[i]++;
            hr[i] += int'(r_v[i]);
            hg[i] += int'(g_v[i]);
            hb[i] += int'(b_v[i]);
          end else begin
            pre_hi[i] += int'(r_v[i]) + int'(g_v[i]) + int'(b_v[i]);
          end
          if (ps_v[i]) begin
            chk("period_start_width", i, int'(prev_ps[i]), 0);
            if (active[i]) begin
              chk("expected_available", i, int'(exp_q[i].size() > 0), 1);
              if (exp_q[i].size() > 0) begin
                mon_e = exp_q[i].pop_front();
                chk("red_high_clocks", i, hr[i], mon_e.r);
                chk("green_high_clocks", i, hg[i], mon_e.g);
                chk("blue_high_clocks", i, hb[i], mon_e.b);
                chk("period_length", i, len_c[i], mon_e.len);
              end
            end else begin
              chk("first_boundary_delay", i, since_rel[i], 255 * int'(DIV_P[i]));
              chk("pre_boundary_highs", i, pre_hi[i], 0);
            end
            active[i] = 1'b1;
            len_c[i]  = 0;
            hr[i]     = 0;
            hg[i]     = 0;
            hb[i]     = 0;
          end
          prev_ps[i] = ps_v[i];
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < NI; i++) io_v[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1;

    // Defaults: idle periods, instant red with ignored upper nibble, reset mid-run.
    release_inst(0);
    push_exp(0, 0, 0, 0);
    push_exp(0, 0, 0, 0);
    push_exp(0, 0, 0, 0);
    run_to(7750);
    io_v[0] = 8'hF9;
    push_exp(0, 255, 0, 0);
    run_to(13750);
    rstn[0] = 1'b0;
    run_to(13752);
    rstn[0] = 1'b1;
    e = 0;
    io_v[0] = 8'h00;
    push_exp(0, 0, 0, 0);
    run_to(5105);
    rstn[0] = 1'b0;

    // CLK_DIV=2: instant red applied mid-period, then green+blue.
    release_inst(1);
    run_to(200);
    io_v[1] = 8'h09;
    push_exp(1, 255, 0, 0);
    push_exp(1, 255, 0, 0);
    run_to(1120);
    io_v[1] = 8'h0E;
    push_exp(1, 0, 255, 255);
    run_to(2045);
    rstn[1] = 1'b0;

    // CLK_DIV=1: red fades up to saturation, then cross-fades with blue and reverses.
    io_v[2] = 8'h01;
    release_inst(2);
    for (int k = 1; k <= 31; k++) push_exp(2, 8 * k, 0, 0);
    push_exp(2, 255, 0, 0);
    push_exp(2, 255, 0, 0);
    run_to(8418);
    io_v[2] = 8'h04;
    push_exp(2, 247, 0, 8);
    push_exp(2, 239, 0, 16);
    run_to(8928);
    io_v[2] = 8'h01;
    push_exp(2, 247, 0, 8);
    run_to(9440);
    rstn[2] = 1'b0;

    // FADE_STEP=100: fade down from 255 must floor at 0.
    io_v[3] = 8'h09;
    release_inst(3);
    push_exp(3, 255, 0, 0);
    run_to(260);
    io_v[3] = 8'h00;
    push_exp(3, 155, 0, 0);
    push_exp(3, 55, 0, 0);
    push_exp(3, 0, 0, 0);
    push_exp(3, 0, 0, 0);
    run_to(1535);
    rstn[3] = 1'b0;

    // MAX_LEVEL=128: io toggles every 100 clocks; only the value at each boundary counts.
    io_v[4] = 8'h0F;
    release_inst(4);
    push_exp(4, 128, 128, 128);
    push_exp(4, 128, 128, 128);
    push_exp(4, 128, 128, 128);
    push_exp(4, 0, 0, 0);
    push_exp(4, 0, 0, 0);
    push_exp(4, 128, 128, 128);
    push_exp(4, 128, 128, 128);
    run_to(600);
    for (int n = 600; n < 2045; n++) begin
      io_v[4] = (((n - 600) / 100) % 2 == 0) ? 8'h08 : 8'h0F;
      run_to(n + 1);
    end
    rstn[4] = 1'b0;

    repeat (4) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) chk("queue_drained", i, exp_q[i].size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
